// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two word requesters, the arbiter and the
// UART transmitter. master = requesters + UART side, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int SIZE        = 8,
  parameter int DATA_LENGTH = 16
);
  // requester side
  logic                   req0;
  logic                   req1;
  logic [DATA_LENGTH-1:0] data0;
  logic [DATA_LENGTH-1:0] data1;
  logic                   ack0;
  logic                   ack1;
  logic                   done0;
  logic                   done1;
  logic                   busy;
  logic                   owner;
  // UART transmitter side
  logic                   tx_start;
  logic [SIZE-1:0]        d_out;
  logic                   tx_done;

  modport master (
    output req0, req1, data0, data1, tx_done,
    input  ack0, ack1, done0, done1, busy, owner, tx_start, d_out
  );

  modport slave (
    input  req0, req1, data0, data1, tx_done,
    output ack0, ack1, done0, done1, busy, owner, tx_start, d_out
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two word
// requesters. The granted word is serialised LSB byte first into SIZE-bit
// bytes, each handed over with a one-cycle tx_start and closed by tx_done.
module uart_tx_arbiter #(
  parameter int SIZE        = 8,
  parameter int DATA_LENGTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int NBYTES = DATA_LENGTH / SIZE;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  generate
    if ((DATA_LENGTH % SIZE) != 0 || NBYTES < 1) begin : g_bad_width
      $error("DATA_LENGTH must be a non-zero multiple of SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                 r_state;
  logic [DATA_LENGTH-1:0] r_shift;
  logic [CW-1:0]          r_byte_cnt;
  logic                   r_last_grant;
  logic                   r_owner;
  logic                   r_busy;
  logic [1:0]             r_ack;
  logic [1:0]             r_done;
  logic                   r_tx_start;
  logic [SIZE-1:0]        r_d_out;

  logic [1:0]             w_req;
  logic                   w_winner;
  logic [DATA_LENGTH-1:0] w_win_data;

  // Sole requester wins; on a tie the port that did not win last time wins,
  // which gives strict alternation when both keep requesting.
  always_comb begin
    w_req      = {bus.req1, bus.req0};
    w_winner   = (&w_req) ? ~r_last_grant : w_req[1];
    w_win_data = w_winner ? bus.data1 : bus.data0;
  end

  // Arbitration + byte serialisation FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_last_grant <= 1'b1;   // port 0 wins the first tie after reset
      r_owner      <= 1'b0;
      r_busy       <= 1'b0;
      r_ack        <= '0;
      r_done       <= '0;
      r_tx_start   <= 1'b0;
      r_d_out      <= '0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_shift         <= w_win_data;
            r_owner         <= w_winner;
            r_last_grant    <= w_winner;
            r_ack[w_winner] <= 1'b1;
            r_busy          <= 1'b1;
            r_byte_cnt      <= '0;
            r_state         <= START;
          end
        end
        START: begin
          r_d_out    <= r_shift[SIZE-1:0];
          r_tx_start <= 1'b1;
          r_shift    <= r_shift >> SIZE;
          r_state    <= WAIT;
        end
        WAIT: begin
          // tx_done only counts here, so stray pulses in IDLE/START never skip a byte
          r_tx_start <= 1'b0;
          if (bus.tx_done) begin
            if (r_byte_cnt == LAST_BYTE) begin
              r_done[r_owner] <= 1'b1;
              r_busy          <= 1'b0;
              r_state         <= IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + CW'(1);
              r_state    <= START;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack0     = r_ack[0];
  assign bus.ack1     = r_ack[1];
  assign bus.done0    = r_done[0];
  assign bus.done1    = r_done[1];
  assign bus.busy     = r_busy;
  assign bus.owner    = r_owner;
  assign bus.tx_start = r_tx_start;
  assign bus.d_out    = r_d_out;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 16-bit and a 24-bit instance share
// clock and reset; the bench plays both requesters and the UART.
module tb_uart_tx_arbiter;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  uart_tx_arbiter_if #(.SIZE(8), .DATA_LENGTH(16)) b16 ();
  uart_tx_arbiter_if #(.SIZE(8), .DATA_LENGTH(24)) b24 ();

  uart_tx_arbiter #(.SIZE(8), .DATA_LENGTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .bus(b16)
  );
  uart_tx_arbiter #(.SIZE(8), .DATA_LENGTH(24)) u_dut24 (
    .clk(clk), .reset(reset), .bus(b24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for tx_start, check the byte and the one-cycle pulse,
  // then return one tx_done pulse.
  task automatic serve_byte(input bit w24, input string tag, input logic [7:0] exp);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if ((w24 ? b24.tx_start : b16.tx_start) === 1'b1) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk({tag, "_start_seen"}, 32'(seen), 32'd1);
    chk({tag, "_byte"}, 32'(w24 ? b24.d_out : b16.d_out), 32'(exp));
    tick();
    chk({tag, "_start_1cyc"}, 32'(w24 ? b24.tx_start : b16.tx_start), 32'd0);
    if (w24) b24.tx_done = 1'b1; else b16.tx_done = 1'b1;
    tick();
    b24.tx_done = 1'b0;
    b16.tx_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    b16.req0 = 0; b16.req1 = 0; b16.data0 = '0; b16.data1 = '0; b16.tx_done = 0;
    b24.req0 = 0; b24.req1 = 0; b24.data0 = '0; b24.data1 = '0; b24.tx_done = 0;
    repeat (3) tick();

    // reset state
    chk("rst_busy",     32'(b16.busy),     32'd0);
    chk("rst_tx_start", 32'(b16.tx_start), 32'd0);
    chk("rst_d_out",    32'(b16.d_out),    32'd0);
    chk("rst_ack0",     32'(b16.ack0),     32'd0);
    chk("rst_done0",    32'(b16.done0),    32'd0);
    chk("rst_owner",    32'(b16.owner),    32'd0);
    chk("rst_busy24",   32'(b24.busy),     32'd0);
    reset = 1'b0;
    tick();

    // 1: single port-0 word A55A -> 5A, A5
    b16.req0 = 1; b16.data0 = 16'hA55A;
    tick();
    chk("t1_ack0",  32'(b16.ack0),  32'd1);
    chk("t1_ack1",  32'(b16.ack1),  32'd0);
    chk("t1_busy",  32'(b16.busy),  32'd1);
    chk("t1_owner", 32'(b16.owner), 32'd0);
    b16.req0 = 0; b16.data0 = 16'h0000;
    tick();
    chk("t1_ack_clr", 32'(b16.ack0), 32'd0);
    serve_byte(0, "t1_b0", 8'h5A);
    chk("t1_no_early_done", 32'(b16.done0), 32'd0);
    serve_byte(0, "t1_b1", 8'hA5);
    chk("t1_done0", 32'(b16.done0), 32'd1);
    chk("t1_busy_lo", 32'(b16.busy), 32'd0);
    tick();
    chk("t1_done_clr", 32'(b16.done0), 32'd0);

    // 2: tie straight out of reset -> port 0 first, then port 1
    reset = 1'b1;
    b16.req0 = 1; b16.data0 = 16'h1111;
    b16.req1 = 1; b16.data1 = 16'h2222;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("t2_ack0",  32'(b16.ack0),  32'd1);
    chk("t2_ack1",  32'(b16.ack1),  32'd0);
    chk("t2_owner", 32'(b16.owner), 32'd0);
    b16.req0 = 0;
    serve_byte(0, "t2_p0b0", 8'h11);
    serve_byte(0, "t2_p0b1", 8'h11);
    chk("t2_done0", 32'(b16.done0), 32'd1);
    tick();
    chk("t2_ack1_after", 32'(b16.ack1),  32'd1);
    chk("t2_owner1",     32'(b16.owner), 32'd1);
    b16.req1 = 0;
    serve_byte(0, "t2_p1b0", 8'h22);
    serve_byte(0, "t2_p1b1", 8'h22);
    chk("t2_done1",    32'(b16.done1), 32'd1);
    chk("t2_done0_lo", 32'(b16.done0), 32'd0);

    // 3: both requesting continuously -> 0,1,0,1
    b16.req0 = 1; b16.req1 = 1;
    for (int g = 0; g < 4; g++) begin
      logic p;
      p = 1'(g % 2);
      tick();
      chk("t3_ack0",  32'(b16.ack0),  32'(!p));
      chk("t3_ack1",  32'(b16.ack1),  32'(p));
      chk("t3_owner", 32'(b16.owner), 32'(p));
      serve_byte(0, "t3_b0", p ? 8'h22 : 8'h11);
      serve_byte(0, "t3_b1", p ? 8'h22 : 8'h11);
      chk("t3_done", 32'(p ? b16.done1 : b16.done0), 32'd1);
    end
    b16.req0 = 0; b16.req1 = 0;
    tick();
    chk("t3_idle", 32'(b16.busy), 32'd0);

    // 4: tx_done in IDLE and in START is ignored
    b16.tx_done = 1;
    tick();
    b16.tx_done = 0;
    chk("t4_idle_busy",  32'(b16.busy),     32'd0);
    chk("t4_idle_done",  32'(b16.done0),    32'd0);
    chk("t4_idle_start", 32'(b16.tx_start), 32'd0);
    b16.req0 = 1; b16.data0 = 16'h3C4B; b16.tx_done = 1;
    tick();
    chk("t4_ack0", 32'(b16.ack0), 32'd1);
    b16.req0 = 0;
    tick();
    b16.tx_done = 0;
    chk("t4_start", 32'(b16.tx_start), 32'd1);
    chk("t4_byte0", 32'(b16.d_out),    32'h4B);
    tick();
    chk("t4_start_lo", 32'(b16.tx_start), 32'd0);
    chk("t4_no_done",  32'(b16.done0),    32'd0);
    chk("t4_busy",     32'(b16.busy),     32'd1);
    b16.tx_done = 1;
    tick();
    b16.tx_done = 0;
    serve_byte(0, "t4_b1", 8'h3C);
    chk("t4_done0", 32'(b16.done0), 32'd1);

    // 5: reset in WAIT of the first byte; held req0 restarts from LSB
    b16.req0 = 1; b16.data0 = 16'h7E81;
    tick();
    chk("t5_ack0", 32'(b16.ack0), 32'd1);
    tick();
    chk("t5_start", 32'(b16.tx_start), 32'd1);
    chk("t5_byte0", 32'(b16.d_out),    32'h81);
    reset = 1'b1;
    tick();
    chk("t5_rst_start", 32'(b16.tx_start), 32'd0);
    chk("t5_rst_busy",  32'(b16.busy),     32'd0);
    chk("t5_rst_d_out", 32'(b16.d_out),    32'd0);
    chk("t5_rst_done",  32'(b16.done0),    32'd0);
    reset = 1'b0;
    tick();
    chk("t5_regrant", 32'(b16.ack0),  32'd1);
    chk("t5_owner",   32'(b16.owner), 32'd0);
    b16.req0 = 0;
    serve_byte(0, "t5_b0", 8'h81);
    serve_byte(0, "t5_b1", 8'h7E);
    chk("t5_done0", 32'(b16.done0), 32'd1);

    // 6: 24-bit build, C0FFEE -> EE, FF, C0
    b24.req0 = 1; b24.data0 = 24'hC0FFEE;
    tick();
    chk("t6_ack0", 32'(b24.ack0), 32'd1);
    b24.req0 = 0;
    serve_byte(1, "t6_b0", 8'hEE);
    chk("t6_no_done_b0", 32'(b24.done0), 32'd0);
    serve_byte(1, "t6_b1", 8'hFF);
    chk("t6_no_done_b1", 32'(b24.done0), 32'd0);
    serve_byte(1, "t6_b2", 8'hC0);
    chk("t6_done0", 32'(b24.done0), 32'd1);
    chk("t6_busy",  32'(b24.busy),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
